fixed_reset_collector: RTL and testbench

Reset-request collector and sequencer: the return path that pairs with the fixed-clock broadcast fan-out. Clients in one clock domain raise reset requests. The block merges them, holds every downstream reset asserted for a fixed time, then releases the resets one at a time in index order. When the release completes, it acknowledges each requester that took part. It sits beside the clock/reset broadcast node and drives that node's per-output reset lines.

---
 rtl/fixed_reset_collector.sv | 134 +++++++++++++
 tb/tb_fixed_reset_collector.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_reset_collector.sv
// rtl/fixed_reset_collector.sv - merges reset requests, holds all outputs, then releases them in index order
module fixed_reset_collector #(
  parameter int N_REQ       = 2,
  parameter int N_OUT       = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGGER     = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] ack,
  output logic [N_OUT-1:0] out_reset,
  output logic             busy
);

  localparam int MAX_CNT = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
  localparam int CW      = $clog2(MAX_CNT) + 1;
  localparam int IW      = $clog2(N_OUT) + 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_OUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_RELEASE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [N_REQ-1:0] mask_q, mask_d;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [N_REQ-1:0] late;
  logic [N_OUT-1:0] out_reset_q, out_reset_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             start_seq;

  // Requests outside the serviced set; in DONE this also covers bits raised that very cycle.
  assign late = pending_q | (req & ~mask_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_ASSERT;
      cnt_q       <= '0;
      idx_q       <= '0;
      mask_q      <= '0;
      pending_q   <= '0;
      out_reset_q <= '1;
      ack_q       <= '0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      mask_q      <= mask_d;
      pending_q   <= pending_d;
      out_reset_q <= out_reset_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    mask_d    = mask_q;
    pending_d = pending_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          mask_d  = req;
          cnt_d   = '0;
          state_d = S_ASSERT;
        end
      end
      S_ASSERT: begin
        mask_d = mask_q | req;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          idx_d   = IW'(1);
          state_d = (N_OUT == 1) ? S_DONE : S_RELEASE;
        end
      end
      S_RELEASE: begin
        pending_d = late;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == STAG_LAST) begin
          cnt_d = '0;
          idx_d = idx_q + IW'(1);
          if (idx_q == IDX_LAST) state_d = S_DONE;
        end
      end
      default: begin
        pending_d = '0;
        if (|late) begin
          mask_d  = late;
          cnt_d   = '0;
          state_d = S_ASSERT;
        end else begin
          mask_d  = '0;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  assign start_seq = (state_d == S_ASSERT) && (state_q != S_ASSERT);

  always_comb begin
    out_reset_d = out_reset_q;
    if (start_seq) begin
      out_reset_d = '1;
    end else if (state_q == S_ASSERT && cnt_q == HOLD_LAST) begin
      out_reset_d[0] = 1'b0;
    end else if (state_q == S_RELEASE && cnt_q == STAG_LAST) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (idx_q == IW'(k)) out_reset_d[k] = 1'b0;
      end
    end
    ack_d  = (state_d == S_DONE) ? mask_d : '0;
    busy_d = (state_d != S_IDLE);
  end

  assign out_reset = out_reset_q;
  assign ack       = ack_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fixed_reset_collector.sv
// tb/tb_fixed_reset_collector.sv - directed scenarios for fixed_reset_collector
module tb_fixed_reset_collector;

  localparam int N_REQ = 2;
  localparam int N_OUT = 3;
  localparam int HOLD  = 4;
  localparam int STAG  = 2;
  localparam int ACK_K = HOLD + (N_OUT - 1) * STAG;

  logic             clock;
  logic             reset;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] ack;
  logic [N_OUT-1:0] out_reset;
  logic             busy;

  int pass_cnt;
  int total_cnt;

  fixed_reset_collector #(
    .N_REQ(N_REQ), .N_OUT(N_OUT), .HOLD_CYCLES(HOLD), .STAGGER(STAG)
  ) dut (
    .clock(clock), .reset(reset), .req(req),
    .ack(ack), .out_reset(out_reset), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Output k is released from sequence cycle HOLD + k*STAG onward.
  function automatic logic [N_OUT-1:0] exp_out(input int k);
    logic [N_OUT-1:0] v;
    for (int j = 0; j < N_OUT; j++) v[j] = (k < HOLD + j * STAG);
    return v;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    req   = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if ({out_reset, busy, ack} !== {3'b111, 1'b1, 2'b00})
        $display("FAIL reset_hold i=%0d got out=%b busy=%b ack=%b want 111 1 00", i, out_reset, busy, ack);
      else pass_cnt++;
    end
    reset = 1'b0;
    for (int k = 0; k <= ACK_K + 1; k++) begin
      total_cnt++;
      if (out_reset !== exp_out(k))
        $display("FAIL poweron_out k=%0d got %b want %b", k, out_reset, exp_out(k));
      else pass_cnt++;
      total_cnt++;
      if (ack !== 2'b00 || busy !== (k <= ACK_K))
        $display("FAIL poweron_ack_busy k=%0d got ack=%b busy=%b want 00 %b", k, ack, busy, (k <= ACK_K));
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_single();
    req = 2'b10;
    tick();
    for (int k = 0; k <= ACK_K; k++) begin
      total_cnt++;
      if (out_reset !== exp_out(k))
        $display("FAIL single_out k=%0d got %b want %b", k, out_reset, exp_out(k));
      else pass_cnt++;
      total_cnt++;
      if (ack !== ((k == ACK_K) ? 2'b10 : 2'b00))
        $display("FAIL single_ack k=%0d got %b want %b", k, ack, (k == ACK_K) ? 2'b10 : 2'b00);
      else pass_cnt++;
      if (k == ACK_K) req = 2'b00;
      tick();
    end
    total_cnt++;
    if ({busy, out_reset, ack} !== 6'b0)
      $display("FAIL single_idle got busy=%b out=%b ack=%b want 0 000 00", busy, out_reset, ack);
    else pass_cnt++;
  endtask

  task automatic test_merge();
    req = 2'b01;
    tick();
    for (int k = 0; k <= ACK_K; k++) begin
      if (k == 1) req = 2'b11;
      total_cnt++;
      if (out_reset !== exp_out(k))
        $display("FAIL merge_out k=%0d got %b want %b", k, out_reset, exp_out(k));
      else pass_cnt++;
      total_cnt++;
      if (ack !== ((k == ACK_K) ? 2'b11 : 2'b00))
        $display("FAIL merge_ack k=%0d got %b want %b", k, ack, (k == ACK_K) ? 2'b11 : 2'b00);
      else pass_cnt++;
      if (k == ACK_K) req = 2'b00;
      tick();
    end
    total_cnt++;
    if (busy !== 1'b0)
      $display("FAIL merge_idle got busy=%b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_late();
    req = 2'b01;
    tick();
    for (int k = 0; k <= ACK_K; k++) begin
      if (k == HOLD + 1) req = 2'b11;
      total_cnt++;
      if (out_reset !== exp_out(k) || ack !== ((k == ACK_K) ? 2'b01 : 2'b00))
        $display("FAIL late_first k=%0d got out=%b ack=%b want %b %b", k, out_reset, ack, exp_out(k), (k == ACK_K) ? 2'b01 : 2'b00);
      else pass_cnt++;
      if (k == ACK_K) req = 2'b10;
      tick();
    end
    for (int k = 0; k <= ACK_K; k++) begin
      total_cnt++;
      if (out_reset !== exp_out(k) || busy !== 1'b1)
        $display("FAIL late_second_out k=%0d got out=%b busy=%b want %b 1", k, out_reset, busy, exp_out(k));
      else pass_cnt++;
      total_cnt++;
      if (ack !== ((k == ACK_K) ? 2'b10 : 2'b00))
        $display("FAIL late_second_ack k=%0d got %b want %b", k, ack, (k == ACK_K) ? 2'b10 : 2'b00);
      else pass_cnt++;
      if (k == ACK_K) req = 2'b00;
      tick();
    end
    total_cnt++;
    if (busy !== 1'b0)
      $display("FAIL late_idle got busy=%b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    req = 2'b01;
    tick();
    for (int k = 0; k <= HOLD + 1; k++) begin
      total_cnt++;
      if (out_reset !== exp_out(k))
        $display("FAIL midrst_pre k=%0d got %b want %b", k, out_reset, exp_out(k));
      else pass_cnt++;
      if (k == HOLD + 1) begin
        reset = 1'b1;
        req   = 2'b00;
      end
      tick();
    end
    total_cnt++;
    if ({out_reset, busy, ack} !== {3'b111, 1'b1, 2'b00})
      $display("FAIL midrst_hit got out=%b busy=%b ack=%b want 111 1 00", out_reset, busy, ack);
    else pass_cnt++;
    reset = 1'b0;
    for (int k = 0; k <= ACK_K + 1; k++) begin
      total_cnt++;
      if (out_reset !== exp_out(k) || ack !== 2'b00 || busy !== (k <= ACK_K))
        $display("FAIL midrst_post k=%0d got out=%b ack=%b busy=%b want %b 00 %b", k, out_reset, ack, busy, exp_out(k), (k <= ACK_K));
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    req = 2'b10;
    tick();
    for (int k = 0; k <= ACK_K; k++) begin
      total_cnt++;
      if (ack !== ((k == ACK_K) ? 2'b10 : 2'b00))
        $display("FAIL hs_ack k=%0d got %b want %b", k, ack, (k == ACK_K) ? 2'b10 : 2'b00);
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if ({busy, out_reset} !== 4'b0)
      $display("FAIL hs_held_idle got busy=%b out=%b want 0 000", busy, out_reset);
    else pass_cnt++;
    req = 2'b00;
    tick();
    total_cnt++;
    if ({busy, out_reset} !== 4'b0)
      $display("FAIL hs_no_retrigger got busy=%b out=%b want 0 000", busy, out_reset);
    else pass_cnt++;

    req = 2'b01;
    tick();
    for (int k = 0; k <= ACK_K; k++) begin
      total_cnt++;
      if (ack !== ((k == ACK_K) ? 2'b01 : 2'b00))
        $display("FAIL hs2_ack k=%0d got %b want %b", k, ack, (k == ACK_K) ? 2'b01 : 2'b00);
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if (busy !== 1'b0)
      $display("FAIL hs2_idle got busy=%b want 0", busy);
    else pass_cnt++;
    tick();
    req = 2'b00;
    total_cnt++;
    if ({busy, out_reset, ack} !== {1'b1, 3'b111, 2'b00})
      $display("FAIL hs2_retrigger got busy=%b out=%b ack=%b want 1 111 00", busy, out_reset, ack);
    else pass_cnt++;
    for (int k = 1; k <= ACK_K; k++) begin
      tick();
      if (k == ACK_K) begin
        total_cnt++;
        if (ack !== 2'b01)
          $display("FAIL hs3_ack got %b want 01", ack);
        else pass_cnt++;
      end
    end
    tick();
    total_cnt++;
    if (busy !== 1'b0)
      $display("FAIL hs3_idle got busy=%b want 0", busy);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset     = 1'b1;
    req       = '0;
    test_reset();
    test_single();
    test_merge();
    test_late();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
